// File: rtl/alu_op_sequencer.sv
// Issues queued ALU requests one at a time, waits the ALU latency and returns C/z with the tag.
// Optional result checker enabled by defining ALU_RESULT_CHECK_EN.
module alu_op_sequencer #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned ALU_LAT = 1,
   parameter int unsigned TAG_W   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [15:0]      req_a,
   input  logic [15:0]      req_b,
   input  logic [2:0]       req_op,
   input  logic [TAG_W-1:0] req_tag,
   output logic [15:0]      alu_a,
   output logic [15:0]      alu_b,
   output logic [2:0]       alu_op,
   input  logic [15:0]      alu_c,
   input  logic             alu_z,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [15:0]      rsp_c,
   output logic             rsp_z,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             rsp_err,
   output logic             busy
);

   localparam int unsigned DW    = 16;
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
   localparam int unsigned LAT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   typedef struct packed {
      logic [DW-1:0]    a;
      logic [DW-1:0]    b;
      logic [2:0]       op;
      logic [TAG_W-1:0] tag;
   } req_t;

   req_t             mem_q [DEPTH];
   req_t             head_c;
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic             req_ready_q;
   logic             push_c, pop_c, capture_c;

   logic [1:0]       state_q, state_d;
   logic [LAT_W-1:0] cnt_q, cnt_d;
   logic [DW-1:0]    alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic [2:0]       alu_op_q, alu_op_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [DW-1:0]    rsp_c_q, rsp_c_d;
   logic             rsp_z_q, rsp_z_d;
   logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
   logic             busy_q;

   assign push_c  = req_valid && req_ready_q;
   assign head_c  = mem_q[rd_ptr_q];
   assign count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);

   // Storage only; validity is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (push_c) begin
         mem_q[wr_ptr_q] <= '{a: req_a, b: req_b, op: req_op, tag: req_tag};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         req_ready_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q     <= count_d;
         req_ready_q <= (count_d != CNT_W'(DEPTH));
         busy_q      <= (count_d != '0) || (state_d != S_IDLE);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_op_q    <= 3'd0;
         tag_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_c_q     <= '0;
         rsp_z_q     <= 1'b0;
         rsp_tag_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_op_q    <= alu_op_d;
         tag_q       <= tag_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_c_q     <= rsp_c_d;
         rsp_z_q     <= rsp_z_d;
         rsp_tag_q   <= rsp_tag_d;
      end
   end

   // Next state: pop_c marks an issue of the FIFO head, shared by IDLE and back-to-back RESP.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_op_d    = alu_op_q;
      tag_d       = tag_q;
      rsp_valid_d = rsp_valid_q;
      rsp_c_d     = rsp_c_q;
      rsp_z_d     = rsp_z_q;
      rsp_tag_d   = rsp_tag_q;
      pop_c       = 1'b0;
      capture_c   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (count_q != '0) pop_c = 1'b1;
            else               alu_op_d = 3'd0;
         end
         S_WAIT: begin
            if (cnt_q == '0) begin
               capture_c   = 1'b1;
               rsp_c_d     = alu_c;
               rsp_z_d     = alu_z;
               rsp_tag_d   = tag_q;
               rsp_valid_d = 1'b1;
               state_d     = S_RESP;
            end else begin
               cnt_d = cnt_q - LAT_W'(1);
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               if (count_q != '0) begin
                  pop_c = 1'b1;
               end else begin
                  alu_op_d = 3'd0;
                  state_d  = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (pop_c) begin
         alu_a_d  = head_c.a;
         alu_b_d  = head_c.b;
         alu_op_d = head_c.op;
         tag_d    = head_c.tag;
         cnt_d    = LAT_W'(ALU_LAT - 1);
         state_d  = S_WAIT;
      end
   end

`ifdef ALU_RESULT_CHECK_EN
   logic [DW-1:0] exp_c_c;
   logic          chk_op_c;
   logic          err_c;
   logic          rsp_err_q;

   // Reference model of the issued operation; NOP and reserved codes are never flagged.
   always_comb begin
      exp_c_c  = '0;
      chk_op_c = 1'b1;
      case (alu_op_q)
         3'd1:    exp_c_c = alu_a_q;
         3'd2:    exp_c_c = alu_a_q + alu_b_q;
         3'd3:    exp_c_c = alu_a_q - alu_b_q;
         3'd4:    exp_c_c = alu_a_q << alu_b_q[3:0];
         3'd6:    exp_c_c = alu_a_q >> alu_b_q[3:0];
         default: chk_op_c = 1'b0;
      endcase
      err_c = chk_op_c && ((alu_c != exp_c_c) || (alu_z != (exp_c_c == '0)));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                       rsp_err_q <= 1'b0;
      else if (capture_c)               rsp_err_q <= err_c;
      else if (rsp_valid_q && rsp_ready) rsp_err_q <= 1'b0;
   end

   assign rsp_err = rsp_err_q;
`else
   assign rsp_err = 1'b0;
`endif

   assign req_ready = req_ready_q;
   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_op    = alu_op_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_c     = rsp_c_q;
   assign rsp_z     = rsp_z_q;
   assign rsp_tag   = rsp_tag_q;
   assign busy      = busy_q;

endmodule
